// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the count timer controller and its counter core.
package count_ctrl_pkg;

    localparam int WIDTH_DEF = 4;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/count_core.sv
// WIDTH-bit up-counter that wraps to zero after reaching the terminal value.
module count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] term,
    output logic [WIDTH-1:0] cnt,
    output logic             at_term
);

    assign at_term = (cnt == term);

    // Count up while enabled, folding back to zero on the terminal value.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= at_term ? '0 : cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_timer_ctrl.sv
// Programmable timer controller: sequences count_core through 0..period-1,
// with one-shot / periodic modes, pause, abort, and completion reporting.
module count_timer_ctrl
    import count_ctrl_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [WIDTH-1:0] wraps
);

    state_t           state, state_n;
    logic [WIDTH-1:0] period_q;
    logic             mode_q;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic             stop_hit, start_ok, start_bad;
    logic             cnt_en, term_evt, core_clr;

    // Terminal count is one below the latched period; unused while idle.
    assign term = period_q - WIDTH'(1);
    assign busy = (state != IDLE);

    count_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .reset   (reset),
        .clear   (core_clr),
        .enable  (cnt_en),
        .term    (term),
        .cnt     (cnt),
        .at_term (at_term)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Command decode and next state; stop outranks start, pause outranks counting.
    always_comb begin
        stop_hit  = stop && (state != IDLE);
        start_ok  = (state == IDLE) && start && !stop && (period != '0);
        start_bad = (state == IDLE) && start && !stop && (period == '0);
        cnt_en    = (state != IDLE) && !stop && !pause;
        term_evt  = cnt_en && at_term;
        core_clr  = stop_hit || start_ok;
        state_n   = state;
        if (stop_hit) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:       if (start_ok) state_n = RUN;
                RUN, PAUSE: begin
                    if (pause)                                 state_n = PAUSE;
                    else if (at_term && mode_q == MODE_ONESHOT) state_n = IDLE;
                    else                                       state_n = RUN;
                end
                default:    state_n = IDLE;
            endcase
        end
    end

    // Latch the run configuration at an accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_q <= '0;
            mode_q   <= MODE_ONESHOT;
        end else if (start_ok) begin
            period_q <= period;
            mode_q   <= mode;
        end
    end

    // Completion / rejection pulses and the saturating completed-period count.
    always_ff @(posedge clk) begin
        if (reset) begin
            done  <= 1'b0;
            err   <= 1'b0;
            wraps <= '0;
        end else begin
            done <= term_evt;
            err  <= start_bad;
            if (start_ok)                      wraps <= '0;
            else if (term_evt && wraps != '1) wraps <= wraps + WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_count_timer_ctrl.sv
// Self-checking bench for count_timer_ctrl: directed vector table, hand-written
// multi-cycle sequences, then randomized traffic against a behavioural model.
module tb_count_timer_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1, start = 1'b0, stop = 1'b0, pause = 1'b0, mode = 1'b0;
    logic [3:0] period = 4'd0;
    logic [3:0] cnt, wraps;
    logic       busy, done, err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    count_timer_ctrl #(.WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .pause(pause),
        .mode(mode), .period(period), .cnt(cnt), .busy(busy), .done(done),
        .err(err), .wraps(wraps)
    );

    typedef struct {
        logic r, s, sp, p, m;
        logic [3:0] per;
        logic [3:0] c;
        logic b, d, e;
        logic [3:0] w;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, sp, p, m, input logic [3:0] per,
                                input logic [3:0] c, input logic b, d, e, input logic [3:0] w);
        vec_t v;
        v.r = r; v.s = s; v.sp = sp; v.p = p; v.m = m; v.per = per;
        v.c = c; v.b = b; v.d = d; v.e = e; v.w = w;
        return v;
    endfunction

    task automatic drive(input logic r, s, sp, p, m, input logic [3:0] per);
        reset = r; start = s; stop = sp; pause = p; mode = m; period = per;
    endtask

    task automatic idle_in();
        drive(0, 0, 0, 0, 0, 4'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [3:0] ec, input logic eb, ed, ee,
                         input logic [3:0] ew);
        n_chk++;
        if ({cnt, busy, done, err, wraps} === {ec, eb, ed, ee, ew}) n_pass++;
        else $display("FAIL %s: got cnt=%0d busy=%0b done=%0b err=%0b wraps=%0d, want cnt=%0d busy=%0b done=%0b err=%0b wraps=%0d",
                      nm, cnt, busy, done, err, wraps, ec, eb, ed, ee, ew);
    endtask

    // Behavioural reference: integer count modulo the period.
    int m_cnt, m_P, m_wraps;
    bit m_busy, m_mode, m_done, m_err;

    task automatic model_step(input bit r, s, sp, p, m, input int per);
        if (r) begin
            m_cnt = 0; m_P = 0; m_wraps = 0; m_busy = 0; m_mode = 0; m_done = 0; m_err = 0;
            return;
        end
        m_done = 0;
        m_err  = 0;
        if (m_busy && sp) begin
            m_busy = 0;
            m_cnt  = 0;
        end else if (!m_busy) begin
            if (s && !sp) begin
                if (per != 0) begin
                    m_P = per; m_mode = m; m_cnt = 0; m_wraps = 0; m_busy = 1;
                end else begin
                    m_err = 1;
                end
            end
        end else if (!p) begin
            m_cnt = (m_cnt + 1) % m_P;
            if (m_cnt == 0) begin
                m_done  = 1;
                m_wraps = (m_wraps < 15) ? m_wraps + 1 : 15;
                if (!m_mode) m_busy = 0;
            end
        end
    endtask

    initial begin
        // ---------------- directed vector table ----------------
        //            r s sp p m per   cnt b d e w
        tbl.push_back(mk(1,0,0,0,0,4'd0, 4'd0,0,0,0,4'd0)); // reset
        tbl.push_back(mk(0,1,0,0,0,4'd5, 4'd0,1,0,0,4'd0)); // one-shot P=5
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd1,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd2,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd3,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd4,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd0,0,1,0,4'd1)); // completion
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd0,0,0,0,4'd1));
        tbl.push_back(mk(0,1,0,0,0,4'd0, 4'd0,0,0,1,4'd1)); // period 0 rejected
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd0,0,0,0,4'd1));
        tbl.push_back(mk(0,1,0,0,0,4'd4, 4'd0,1,0,0,4'd0)); // P=4
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd1,1,0,0,4'd0));
        tbl.push_back(mk(0,1,0,0,1,4'd9, 4'd2,1,0,0,4'd0)); // start while busy ignored
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd3,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd0,0,1,0,4'd1)); // done at edge 4
        tbl.push_back(mk(0,1,0,0,0,4'd4, 4'd0,1,0,0,4'd0)); // terminal + pause
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd1,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd2,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd3,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1,0,4'd0, 4'd3,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1,0,4'd0, 4'd3,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd0,0,1,0,4'd1)); // release -> done
        tbl.push_back(mk(0,1,0,0,1,4'd7, 4'd0,1,0,0,4'd0)); // stop while paused
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd1,1,0,0,4'd0));
        tbl.push_back(mk(0,0,0,1,0,4'd0, 4'd1,1,0,0,4'd0));
        tbl.push_back(mk(0,0,1,1,0,4'd0, 4'd0,0,0,0,4'd0));
        tbl.push_back(mk(0,1,1,0,0,4'd3, 4'd0,0,0,0,4'd0)); // stop beats start in idle
        tbl.push_back(mk(0,1,0,0,1,4'd2, 4'd0,1,0,0,4'd0)); // periodic P=2
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd1,1,0,0,4'd0));
        tbl.push_back(mk(1,0,0,0,0,4'd0, 4'd0,0,0,0,4'd0)); // reset mid-run
        tbl.push_back(mk(0,0,0,0,0,4'd0, 4'd0,0,0,0,4'd0));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].r, tbl[i].s, tbl[i].sp, tbl[i].p, tbl[i].m, tbl[i].per);
            step();
            check($sformatf("vec%0d", i), tbl[i].c, tbl[i].b, tbl[i].d, tbl[i].e, tbl[i].w);
        end

        // ---------------- periodic P=3, 10 cycles, then stop ----------------
        drive(0, 1, 0, 0, 1, 4'd3);
        step();
        check("per3_start", 4'd0, 1, 0, 0, 4'd0);
        idle_in();
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("per3_e%0d", i), 4'(i % 3), 1, (i % 3 == 0), 0, 4'(i / 3));
        end
        drive(0, 0, 1, 0, 0, 4'd0);
        step();
        check("per3_stop", 4'd0, 0, 0, 0, 4'd3);
        idle_in();
        for (int i = 0; i < 3; i++) begin
            step();
            check("per3_after", 4'd0, 0, 0, 0, 4'd3);
        end

        // ---------------- one-shot P=6 with 4 paused cycles at cnt=2 ----------------
        begin
            int exp_c[11] = '{0, 1, 2, 2, 2, 2, 2, 3, 4, 5, 0};
            drive(0, 1, 0, 0, 0, 4'd6);
            step();
            check("pz_e0", 4'd0, 1, 0, 0, 4'd0);
            for (int e = 1; e <= 10; e++) begin
                drive(0, 0, 0, (e >= 3 && e <= 6), 0, 4'd0);
                step();
                check($sformatf("pz_e%0d", e), 4'(exp_c[e]), (e != 10), (e == 10), 0,
                      4'(e == 10 ? 1 : 0));
            end
            idle_in();
        end

        // ---------------- periodic P=1, 20 cycles, wraps saturates ----------------
        drive(0, 1, 0, 0, 1, 4'd1);
        step();
        check("p1_start", 4'd0, 1, 0, 0, 4'd0);
        idle_in();
        for (int i = 1; i <= 20; i++) begin
            step();
            check($sformatf("p1_e%0d", i), 4'd0, 1, 1, 0, 4'(i > 15 ? 15 : i));
        end
        drive(0, 0, 1, 0, 0, 4'd0);
        step();
        check("p1_stop", 4'd0, 0, 0, 0, 4'd15);

        // ---------------- randomized traffic vs model ----------------
        drive(1, 0, 0, 0, 0, 4'd0);
        step();
        model_step(1, 0, 0, 0, 0, 0);
        check("rnd_reset", 4'(m_cnt), m_busy, m_done, m_err, 4'(m_wraps));
        for (int i = 0; i < 3000; i++) begin
            bit r, s, sp, p, m;
            int per;
            r   = ($urandom_range(99) == 0);
            s   = ($urandom_range(5) == 0);
            sp  = ($urandom_range(39) == 0);
            p   = ($urandom_range(4) == 0);
            m   = 1'($urandom_range(1));
            per = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(15));
            drive(r, s, sp, p, m, 4'(per));
            step();
            model_step(r, s, sp, p, m, per);
            check($sformatf("rnd%0d", i), 4'(m_cnt), m_busy, m_done, m_err, 4'(m_wraps));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
